// File: rtl/io_pkg.sv
// io_pkg: shared constants for the switch/button event controller.
// Holds input widths, the LSU address windows and the debounce FSM state type.
// No ports; imported by input_debounce and input_event_ctrl.
package io_pkg;

  localparam int SW_W  = 18;
  localparam int BTN_W = 4;

  // Inclusive byte-address windows on the LSU I/O port.
  localparam logic [15:0] SW_BASE   = 16'h7800;
  localparam logic [15:0] SW_LAST   = 16'h780F;
  localparam logic [15:0] BTN_BASE  = 16'h7810;
  localparam logic [15:0] BTN_LAST  = 16'h7813;
  localparam logic [15:0] PEND_BASE = 16'h7814;
  localparam logic [15:0] PEND_LAST = 16'h7817;
  localparam logic [15:0] MASK_BASE = 16'h7818;
  localparam logic [15:0] MASK_LAST = 16'h781B;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } dbnc_state_e;

  function automatic logic in_window(input logic [15:0] a,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: one-bit debouncer clocked by a shared sample tick.
// Ports: i_clk, i_rst (sync, active-high), tick (sample strobe), sync_i (synchronised raw bit)
//        -> level_o (registered debounced level), rise_o (1-cycle pulse on entry to ST_HI).
module input_debounce
  import io_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic tick,
  input  logic sync_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [7:0] SS = 8'(STABLE_SAMPLES);

  dbnc_state_e state;
  logic [7:0]  cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_LO;
      cnt     <= 8'd0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      if (tick) begin
        case (state)
          ST_LO: if (sync_i) begin
            if (SS == 8'd1) begin
              state   <= ST_HI;
              cnt     <= 8'd0;
              level_o <= 1'b1;
              rise_o  <= 1'b1;
            end else begin
              state <= CHK_HI;
              cnt   <= 8'd1;
            end
          end
          CHK_HI: begin
            if (sync_i) begin
              // cnt counts the differing ticks seen so far, including this one.
              if (cnt + 8'd1 >= SS) begin
                state   <= ST_HI;
                cnt     <= 8'd0;
                level_o <= 1'b1;
                rise_o  <= 1'b1;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end else begin
              state <= ST_LO;
              cnt   <= 8'd0;
            end
          end
          ST_HI: if (!sync_i) begin
            if (SS == 8'd1) begin
              state   <= ST_LO;
              cnt     <= 8'd0;
              level_o <= 1'b0;
            end else begin
              state <= CHK_LO;
              cnt   <= 8'd1;
            end
          end
          CHK_LO: begin
            if (!sync_i) begin
              if (cnt + 8'd1 >= SS) begin
                state   <= ST_LO;
                cnt     <= 8'd0;
                level_o <= 1'b0;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end else begin
              state <= ST_HI;
              cnt   <= 8'd0;
            end
          end
          default: begin
            state   <= ST_LO;
            cnt     <= 8'd0;
            level_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/input_event_ctrl.sv
// input_event_ctrl: LSU-mapped switch/button controller with debounce, sticky press flags and IRQ.
// Ports: i_clk, i_rst (sync, active-high); io_sw_i[17:0], io_btn_i[3:0] raw async inputs;
//        addr_i/i_rd_en/i_wr_en/i_st_data load-store port -> o_ld_data/o_ld_valid (1-cycle), o_irq.
module input_event_ctrl
  import io_pkg::*;
#(
  parameter int TICK_DIV       = 500,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SW_W-1:0]   io_sw_i,
  input  logic [BTN_W-1:0]  io_btn_i,
  input  logic [15:0]       addr_i,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [31:0]       i_st_data,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_valid,
  output logic              o_irq
);

  localparam int IN_W = SW_W + BTN_W;
  localparam int TW   = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Bits [SW_W-1:0] are switches, the top BTN_W bits are buttons.
  logic [IN_W-1:0]  sync1, sync2;
  logic [IN_W-1:0]  level, rise;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [BTN_W-1:0] pending, mask, pend_clr;
  logic [31:0]      rd_mux;

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar g = 0; g < IN_W; g++) begin : g_dbnc
    input_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_dbnc (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .tick    (tick),
      .sync_i  (sync2[g]),
      .level_o (level[g]),
      .rise_o  (rise[g])
    );
  end

  // Switch edges are not events; only button presses latch into pending.
  logic unused_ok;
  assign unused_ok = ^{rise[SW_W-1:0], i_st_data[31:BTN_W]};

  always_comb begin
    pend_clr = '0;
    if (i_wr_en && in_window(addr_i, PEND_BASE, PEND_LAST))
      pend_clr = i_st_data[BTN_W-1:0];
  end

  // Read mux uses the current register values, so a load sharing a cycle
  // with a store returns the pre-store contents.
  always_comb begin
    rd_mux = 32'd0;
    if (in_window(addr_i, SW_BASE, SW_LAST))
      rd_mux = {14'd0, level[SW_W-1:0]};
    else if (in_window(addr_i, BTN_BASE, BTN_LAST))
      rd_mux = {28'd0, level[IN_W-1:SW_W]};
    else if (in_window(addr_i, PEND_BASE, PEND_LAST))
      rd_mux = {28'd0, pending};
    else if (in_window(addr_i, MASK_BASE, MASK_LAST))
      rd_mux = {28'd0, mask};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1      <= '0;
      sync2      <= '0;
      tick_cnt   <= '0;
      pending    <= '0;
      mask       <= '0;
      o_irq      <= 1'b0;
      o_ld_data  <= 32'd0;
      o_ld_valid <= 1'b0;
    end else begin
      sync1    <= {io_btn_i, io_sw_i};
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      // OR-ing the set after the clear lets a same-cycle press win.
      pending  <= (pending & ~pend_clr) | rise[IN_W-1:SW_W];
      if (i_wr_en && in_window(addr_i, MASK_BASE, MASK_LAST))
        mask <= i_st_data[BTN_W-1:0];
      o_irq      <= |(pending & mask);
      o_ld_valid <= i_rd_en;
      if (i_rd_en)
        o_ld_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_input_event_ctrl.sv
// tb_input_event_ctrl: scoreboard bench for input_event_ctrl with TICK_DIV=4, STABLE_SAMPLES=3.
// Loads push expected data into a queue; a negedge monitor pops and compares on o_ld_valid.
// Scenario tasks also compare o_irq / hold behaviour inline.
module tb_input_event_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sw = '0;
  logic [3:0]  btn = '0;
  logic [15:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] st_data = '0;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        irq;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  input_event_ctrl #(.TICK_DIV(4), .STABLE_SAMPLES(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .io_sw_i    (sw),
    .io_btn_i   (btn),
    .addr_i     (addr),
    .i_rd_en    (rd_en),
    .i_wr_en    (wr_en),
    .i_st_data  (st_data),
    .o_ld_data  (ld_data),
    .o_ld_valid (ld_valid),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid load beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ld_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ld_unexpected: ld_valid=1 data=%h with no load outstanding", ld_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string nm = name_q.pop_front();
        if (ld_data !== e) begin
          errors++;
          $display("FAIL %s: ld_data=%h expected %h", nm, ld_data, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_push(input logic [15:0] a, input logic [31:0] e, input string nm);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] e, input string nm);
    load_push(a, e, nm);
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = a;
    st_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      btn = 4'($urandom);
      sw  = 18'($urandom);
      step(1);
    end
    rst = 1'b0;
    btn = '0;
    sw  = '0;
    @(negedge clk);
    vectors++;
    if (ld_data !== 32'd0) begin errors++; $display("FAIL rst_ld_data: got %h expected 0", ld_data); end
    vectors++;
    if (ld_valid !== 1'b0) begin errors++; $display("FAIL rst_ld_valid: got %b expected 0", ld_valid); end
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    step(1);
    load(16'h7814, 32'd0, "rst_pending");
    load(16'h7818, 32'd0, "rst_mask");
    load(16'h7810, 32'd0, "rst_btn_db");
    load(16'h7800, 32'd0, "rst_sw_db");
    step(2);
  endtask

  task automatic test_clean_press;
    do_reset(2);
    btn = 4'b0001;
    step(11);
    // Ticks land on edges 4, 8, 12 after reset: level flips at edge 12.
    load_push(16'h7810, 32'd0, "press_level_before");
    step(1);
    load_push(16'h7810, 32'd1, "press_level_after");
    step(1);
    rd_en = 1'b0;
    load(16'h7814, 32'd1, "press_pending");
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked: got %b expected 0", irq); end
    step(1);
    store(16'h7818, 32'd1);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
    step(1);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked: got %b expected 1", irq); end
    step(1);
    store(16'h7814, 32'h0000_0001);
    step(1);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq); end
    step(1);
    load(16'h7814, 32'd0, "pending_w1c");
    // Load and store to mask in one cycle: load sees old mask.
    rd_en = 1'b1; wr_en = 1'b1; addr = 16'h7818; st_data = 32'hF;
    exp_q.push_back(32'd1);
    name_q.push_back("mask_pre_store");
    step(1);
    rd_en = 1'b0; wr_en = 1'b0;
    load(16'h7818, 32'hF, "mask_post_store");
    btn = '0;
    step(2);
  endtask

  task automatic test_bounce;
    do_reset(2);
    btn = 4'b0100; step(5);
    btn = 4'b0000; step(5);
    btn = 4'b0100; step(5);
    btn = 4'b0000; step(20);
    load(16'h7810, 32'd0, "bounce_level");
    load(16'h7814, 32'd0, "bounce_pending");
    step(2);
  endtask

  task automatic test_collision;
    do_reset(2);
    btn = 4'b0100;
    step(11);
    // W1C of bit 2 held across edges 12 and 13, covering the cycle the press lands.
    wr_en = 1'b1; addr = 16'h7814; st_data = 32'h4;
    step(2);
    wr_en = 1'b0;
    load(16'h7814, 32'h4, "collision_set_wins");
    btn = '0;
    step(2);
  endtask

  task automatic test_switch;
    sw = 18'h2A5A5;
    step(30);
    load(16'h7800, 32'h0002_A5A5, "sw_read");
    load(16'h780C, 32'h0002_A5A5, "sw_read_window_top");
    load(16'h7820, 32'd0, "unmapped_read");
    load(16'h781C, 32'd0, "past_mask_read");
    store(16'h7800, 32'hFFFF_FFFF);
    load(16'h7800, 32'h0002_A5A5, "sw_read_only");
    step(1);
    @(negedge clk);
    vectors++;
    if (ld_valid !== 1'b0) begin errors++; $display("FAIL ld_valid_drop: got %b expected 0", ld_valid); end
    vectors++;
    if (ld_data !== 32'h0002_A5A5) begin errors++; $display("FAIL ld_data_hold: got %h expected 0002a5a5", ld_data); end
    sw = '0;
    step(2);
  endtask

  task automatic test_reset_mid;
    int first;
    first = 0;
    do_reset(2);
    btn = 4'b0001;
    step(7);
    // FSM for btn[0] is in CHK_HI here; reset it with the button still held.
    do_reset(2);
    store(16'h7818, 32'd1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (irq === 1'b1 && first == 0) first = n;
      if (first != 0) break;
      step(1);
    end
    vectors++;
    if (first == 0) begin
      errors++;
      $display("FAIL reset_mid_press: no irq within 40 cycles, expected at cycle 11..19");
    end else if (first < 11 || first > 19) begin
      errors++;
      $display("FAIL reset_mid_press: irq at cycle %0d, expected 11..19", first);
    end
    btn = '0;
    step(2);
    load(16'h7814, 32'd1, "reset_mid_pending");
    step(2);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_collision();
    test_switch();
    test_reset_mid();
    step(3);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ld_missing: %0d loads never returned, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_event_ctrl.md
# input_event_ctrl

Memory-mapped controller for the board switches and push-buttons on the single-cycle core's LSU I/O port. It synchronises and debounces all raw inputs, and latches button presses into a sticky pending register. It also raises a maskable level interrupt. The LSU reads debounced state and event flags through it instead of sampling raw pins.

## Interface
- `TICK_DIV`, default 500: sample-tick period in `i_clk` cycles, minimum 2.
- `STABLE_SAMPLES`, default 4: consecutive differing ticks needed to accept a new level, minimum 1.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `io_sw_i`  in  18  raw switches, asynchronous.
- `io_btn_i`  in  4  raw buttons, asynchronous, 1 = pressed.
- `addr_i`  in  16  LSU byte address.
- `i_rd_en`  in  1  load strobe.
- `i_wr_en`  in  1  store strobe.
- `i_st_data`  in  32  store data.
- `o_ld_data`  out  32  registered load data.
- `o_ld_valid`  out  1  load data valid.
- `o_irq`  out  1  `|(pending & mask)`, registered.

## Operation
- **Synchroniser:** all 22 raw bits pass through a 2-flop synchroniser.
- **Tick counter:** counts 0..`TICK_DIV`-1 and wraps. `tick` is a 1-cycle pulse on the cycle the count equals `TICK_DIV`-1.
- **Debounce FSM:** one instance per bit, states `ST_LO`, `CHK_HI`, `ST_HI`, `CHK_LO`; 8-bit sample counter `cnt`. State changes only on `tick` cycles.
  - `ST_LO`, sync=1: go to `CHK_HI`, `cnt`=1.
  - `CHK_HI`, sync=1: `cnt`++. When `cnt` reaches `STABLE_SAMPLES`, go to `ST_HI`.
  - `CHK_HI`, sync=0: go back to `ST_LO`, `cnt`=0.
  - `ST_HI`/`CHK_LO`: mirror image of the above.
  - With `STABLE_SAMPLES`=1, `ST_LO` goes directly to `ST_HI` on the first differing tick.
  - Debounced level is 1 in `ST_HI` and `CHK_LO`.
- **Press event:** a button FSM entering `ST_HI` pulses `rise[i]`. A release produces no event.
- **Register map** (decode on `addr_i` only):
  - `0x7800`–`0x780F`: read `{14'b0, sw_db}`. Writes ignored.
  - `0x7810`–`0x7813`: read `{28'b0, btn_db}`. Writes ignored.
  - `0x7814`–`0x7817`: pending[3:0], read. Writing with `i_wr_en` clears the bits where `i_st_data[3:0]` is 1 (write-1-to-clear).
  - `0x7818`–`0x781B`: mask[3:0], read/write.
  - All other addresses: read 0, writes ignored.
- **Pending update:** pending[i] sets on `rise[i]`. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- **Same-cycle load and store:** a load returns the pre-store value.

## Timing
- **Reset values:** `o_ld_data`=0, `o_ld_valid`=0, `o_irq`=0. Synchroniser flops 0, tick counter 0, all FSMs `ST_LO` with `cnt`=0, pending=0, mask=0.
- **Load latency:** 1 cycle. `i_rd_en` in cycle n gives `o_ld_data`/`o_ld_valid` in cycle n+1. `o_ld_valid` is high for exactly one cycle per strobe, and back-to-back strobes are supported. `o_ld_data` holds its value when no load is active.
- **Input latency:** a raw change reaches the sync output after 2 cycles. The debounced level follows on the `STABLE_SAMPLES`-th consecutive tick after that.
- **Interrupt latency:** `o_irq` updates 1 cycle after pending or mask changes.
- **Reset mid-operation:** all state returns to its reset value. A button held through reset is debounced from `ST_LO` after reset and produces a press event.

## Structure
- **Shared package `io_pkg`:** the four address window constants, the `dbnc_state_e` enum and the width constants `SW_W`=18 and `BTN_W`=4.
- **Sub-module `input_debounce`:** one bit's FSM and counter, with inputs `i_clk`, `i_rst`, `tick`, `sync_i` and outputs `level_o`, `rise_o`. The top level instantiates it 22 times in a generate loop.
- **Top level:** owns the synchroniser, tick counter, register file and read mux.

## Test plan
All scenarios use `TICK_DIV`=4 and `STABLE_SAMPLES`=3.
- **Reset:** hold `i_rst` for 2 cycles with inputs toggling. Every output is 0, and a load of `0x7814` returns 0.
- **Clean press:** `io_btn_i`=`4'b0001` held for 30 cycles. Load `0x7810` returns 1 after sync plus 3 ticks; pending=1; `o_irq` stays 0 (mask 0). Store 1 to `0x7818`, then `o_irq`=1 one cycle later.
- **Bounce rejection:** `btn[2]` pulses high for 5 cycles, low, then high again for 5 cycles. The debounced level stays 0 and pending stays 0.
- **Set/clear collision:** issue a W1C store of `0x4` to `0x7814` in the same cycle as `rise[2]`. pending[2] stays 1.
- **Switch read:** `io_sw_i`=`18'h2A5A5` stable. Load `0x7800` returns `0x0002A5A5`; load `0x7820` returns 0 with `o_ld_valid`=1.
- **Reset mid-debounce:** assert `i_rst` while `btn[0]` is in `CHK_HI` with the button still held. After release from reset, pending[0] sets 2 + 3×4 cycles (±4) later.
